cdb_arbiter: RTL and testbench



---
 rtl/tomasulo_pkg.sv | 22 ++
 rtl/rr_pick4.sv | 28 ++
 rtl/cdb_arbiter.sv | 130 +++++++++++++
 tb/tb_cdb_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo datapath constants: result/tag widths, the "no tag" value and the
// indices of the four CDB producers.
package tomasulo_pkg;

  localparam int DATA_W     = 32;
  localparam int LABEL_W    = 4;
  localparam int LABEL_NONE = 0;
  localparam int NUM_SRC    = 4;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MUL = 2'd1,
    SRC_DIV = 2'd2,
    SRC_LS  = 2'd3
  } src_e;

  // Source index that follows the given winner in rotating search order.
  function automatic logic [1:0] src_after(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way pick: the first requester found searching upward from start_i
// (mod 4) wins; gnt_o is one-hot, or zero when nothing requests.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] start_i,
  output logic [3:0] gnt_o,
  output logic [1:0] idx_o
);

  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] offset;

  // Doubling the vector turns the wrap-around search into a plain rotate.
  assign req_dbl = {req_i, req_i} >> start_i;
  assign req_rot = req_dbl[3:0];

  always_comb begin
    offset = 2'd3;
    if (req_rot[0])      offset = 2'd0;
    else if (req_rot[1]) offset = 2'd1;
    else if (req_rot[2]) offset = 2'd2;
  end

  assign idx_o = start_i + offset;
  assign gnt_o = (|req_i) ? (4'b0001 << idx_o) : 4'b0000;

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: same-cycle grant, registered broadcast, starvation and zero-tag flags.
// Define CDB_ROUND_ROBIN_EN for rotating-pointer arbitration; otherwise ALU > MUL > DIV > LS.
module cdb_arbiter #(
  parameter int DATA_W   = tomasulo_pkg::DATA_W,
  parameter int LABEL_W  = tomasulo_pkg::LABEL_W,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [3:0]         require,
  input  logic [DATA_W-1:0]  data0,
  input  logic [DATA_W-1:0]  data1,
  input  logic [DATA_W-1:0]  data2,
  input  logic [DATA_W-1:0]  data3,
  input  logic [LABEL_W-1:0] label0,
  input  logic [LABEL_W-1:0] label1,
  input  logic [LABEL_W-1:0] label2,
  input  logic [LABEL_W-1:0] label3,
  output logic [3:0]         requireAC,
  output logic               BCEN,
  output logic [LABEL_W-1:0] BClabel,
  output logic [DATA_W-1:0]  BCdata,
  output logic [3:0]         starve,
  output logic               labelErr
);

  import tomasulo_pkg::*;

  localparam logic [WAIT_W-1:0]  WAIT_SAT = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0]  WAIT_LIM = WAIT_W'(MAX_WAIT);
  localparam logic [LABEL_W-1:0] NO_TAG   = LABEL_W'(LABEL_NONE);

  logic [NUM_SRC-1:0] pick_gnt;
  logic [1:0]         win_idx;
  logic [1:0]         start_ptr;
  logic               granted;

  logic [DATA_W-1:0]  data_arr  [NUM_SRC];
  logic [LABEL_W-1:0] label_arr [NUM_SRC];
  logic [DATA_W-1:0]  win_data;
  logic [LABEL_W-1:0] win_label;

  logic               bcen_q, bcen_d;
  logic [LABEL_W-1:0] label_q, label_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               label_err_q, label_err_d;
  logic [NUM_SRC-1:0] starve_q, starve_d;
  logic [WAIT_W-1:0]  wait_q [NUM_SRC];
  logic [WAIT_W-1:0]  wait_d [NUM_SRC];

  assign data_arr  = '{data0, data1, data2, data3};
  assign label_arr = '{label0, label1, label2, label3};

`ifdef CDB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  assign start_ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (granted) ptr_d = src_after(win_idx);
  end

  always_ff @(posedge clk) begin
    if (RST) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end
`else
  assign start_ptr = 2'd0;
`endif

  rr_pick4 u_pick (
    .req_i   (require),
    .start_i (start_ptr),
    .gnt_o   (pick_gnt),
    .idx_o   (win_idx)
  );

  // Grant is gated by reset so a request in the reset cycle releases nobody.
  assign requireAC = RST ? 4'b0000 : pick_gnt;
  assign granted   = |requireAC;
  assign win_data  = data_arr[win_idx];
  assign win_label = label_arr[win_idx];

  always_comb begin
    bcen_d      = granted && (win_label != NO_TAG);
    label_d     = label_q;
    data_d      = data_q;
    label_err_d = label_err_q | (granted && (win_label == NO_TAG));
    if (granted) begin
      label_d = win_label;
      data_d  = win_data;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!require[i] || requireAC[i])  wait_d[i] = '0;
      else if (wait_q[i] == WAIT_SAT)   wait_d[i] = wait_q[i];
      else                              wait_d[i] = wait_q[i] + WAIT_W'(1);
      starve_d[i] = (wait_d[i] >= WAIT_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      bcen_q      <= 1'b0;
      label_q     <= '0;
      data_q      <= '0;
      label_err_q <= 1'b0;
      starve_q    <= '0;
      for (int i = 0; i < NUM_SRC; i++) wait_q[i] <= '0;
    end else begin
      bcen_q      <= bcen_d;
      label_q     <= label_d;
      data_q      <= data_d;
      label_err_q <= label_err_d;
      starve_q    <= starve_d;
      for (int i = 0; i < NUM_SRC; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign BCEN     = bcen_q;
  assign BClabel  = label_q;
  assign BCdata   = data_q;
  assign starve   = starve_q;
  assign labelErr = label_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus random traffic against a behavioural model,
// on a default instance and a narrow-counter instance (WAIT_W=2, MAX_WAIT=3).
module tb_cdb_arbiter;

  localparam int DW = 32;
  localparam int LW = 4;
  localparam int A_MAX = 8;
  localparam int A_SAT = 15;
  localparam int B_MAX = 3;
  localparam int B_SAT = 3;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [LW-1:0] lbl [4];
  logic [DW-1:0] dat [4];
  logic [LW-1:0] s_lbl [4];
  logic [DW-1:0] s_dat [4];

  logic [3:0]    ac_a, ac_b, st_a, st_b;
  logic          bcen_a, bcen_b, err_a, err_b;
  logic [LW-1:0] bl_a, bl_b;
  logic [DW-1:0] bd_a, bd_b;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: current (m_*) and next (n_*) state
  int            m_ptr, n_ptr;
  int            w_a [4];
  int            w_b [4];
  int            nw_a [4];
  int            nw_b [4];
  logic          m_bcen, n_bcen, m_err, n_err;
  logic [LW-1:0] m_lbl, n_lbl;
  logic [DW-1:0] m_dat, n_dat;
  logic [3:0]    m_st_a, n_st_a, m_st_b, n_st_b, m_ac;

  cdb_arbiter dut_a (
    .clk(clk), .RST(rst), .require(req),
    .data0(dat[0]), .data1(dat[1]), .data2(dat[2]), .data3(dat[3]),
    .label0(lbl[0]), .label1(lbl[1]), .label2(lbl[2]), .label3(lbl[3]),
    .requireAC(ac_a), .BCEN(bcen_a), .BClabel(bl_a), .BCdata(bd_a),
    .starve(st_a), .labelErr(err_a)
  );

  cdb_arbiter #(.DATA_W(DW), .LABEL_W(LW), .WAIT_W(2), .MAX_WAIT(3)) dut_b (
    .clk(clk), .RST(rst), .require(req),
    .data0(dat[0]), .data1(dat[1]), .data2(dat[2]), .data3(dat[3]),
    .label0(lbl[0]), .label1(lbl[1]), .label2(lbl[2]), .label3(lbl[3]),
    .requireAC(ac_b), .BCEN(bcen_b), .BClabel(bl_b), .BCdata(bd_b),
    .starve(st_b), .labelErr(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle: commit the model at the edge, then drive new inputs and predict the grant.
  task automatic apply(input logic r, input logic [3:0] rq);
    int win;
    @(posedge clk);
    m_ptr = n_ptr; m_bcen = n_bcen; m_lbl = n_lbl; m_dat = n_dat; m_err = n_err;
    m_st_a = n_st_a; m_st_b = n_st_b;
    for (int i = 0; i < 4; i++) begin w_a[i] = nw_a[i]; w_b[i] = nw_b[i]; end
    #1;
    rst = r;
    req = rq;
    for (int i = 0; i < 4; i++) begin lbl[i] = s_lbl[i]; dat[i] = s_dat[i]; end
    win = -1;
    if (!r && rq != 4'b0000) begin
`ifdef CDB_ROUND_ROBIN_EN
      for (int k = 0; k < 4; k++) if (win < 0 && rq[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
`else
      for (int k = 0; k < 4; k++) if (win < 0 && rq[k]) win = k;
`endif
    end
    m_ac = (win >= 0) ? (4'b0001 << win) : 4'b0000;
    if (r) begin
      n_ptr = 0; n_bcen = 0; n_lbl = '0; n_dat = '0; n_err = 0; n_st_a = '0; n_st_b = '0;
      for (int i = 0; i < 4; i++) begin nw_a[i] = 0; nw_b[i] = 0; end
    end else begin
      n_ptr = m_ptr; n_bcen = 0; n_lbl = m_lbl; n_dat = m_dat; n_err = m_err;
      if (win >= 0) begin
        n_ptr  = (win + 1) % 4;
        n_bcen = (s_lbl[win] != 0);
        n_lbl  = s_lbl[win];
        n_dat  = s_dat[win];
        if (s_lbl[win] == 0) n_err = 1;
      end
      for (int i = 0; i < 4; i++) begin
        if (!rq[i] || i == win) begin
          nw_a[i] = 0; nw_b[i] = 0;
        end else begin
          nw_a[i] = (w_a[i] + 1 > A_SAT) ? A_SAT : w_a[i] + 1;
          nw_b[i] = (w_b[i] + 1 > B_SAT) ? B_SAT : w_b[i] + 1;
        end
        n_st_a[i] = (nw_a[i] >= A_MAX);
        n_st_b[i] = (nw_b[i] >= B_MAX);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin s_lbl[i] = LW'(i + 1); s_dat[i] = 32'hA000 + i; end
    apply(1'b1, 4'b1111);
    n_checks++; if (ac_a !== 4'b0000) begin n_fail++; $display("FAIL reset_ac: got %b expected 0000", ac_a); end
    n_checks++; if (bcen_a !== 1'b0 || bl_a !== '0 || bd_a !== '0) begin n_fail++;
      $display("FAIL reset_bc: got bcen=%b lbl=%0h data=%0h expected all zero", bcen_a, bl_a, bd_a); end
    n_checks++; if (st_a !== 4'b0000 || err_a !== 1'b0) begin n_fail++;
      $display("FAIL reset_flags: got starve=%b err=%b expected 0000/0", st_a, err_a); end
    apply(1'b0, 4'b0000);
    n_checks++; if (bcen_a !== 1'b0) begin n_fail++; $display("FAIL reset_grant_suppressed: got bcen=%b expected 0", bcen_a); end
  endtask

  task automatic test_single();
    s_lbl[0] = 4'd3; s_dat[0] = 32'h1234;
    apply(1'b0, 4'b0001);
    n_checks++; if (ac_a !== 4'b0001) begin n_fail++; $display("FAIL single_ac: got %b expected 0001", ac_a); end
    apply(1'b0, 4'b0000);
    n_checks++; if (bcen_a !== 1'b1 || bl_a !== 4'd3 || bd_a !== 32'h1234) begin n_fail++;
      $display("FAIL single_bc: got bcen=%b lbl=%0d data=%0h expected 1/3/1234", bcen_a, bl_a, bd_a); end
    n_checks++; if (ac_a !== 4'b0000) begin n_fail++; $display("FAIL single_idle_ac: got %b expected 0000", ac_a); end
  endtask

  task automatic test_all_request();
    logic [3:0] exp_ac;
    for (int i = 0; i < 4; i++) begin s_lbl[i] = LW'(i + 1); s_dat[i] = 32'hB000 + i; end
    apply(1'b1, 4'b0000);
    for (int c = 0; c < 10; c++) begin
      apply(1'b0, 4'b1111);
`ifdef CDB_ROUND_ROBIN_EN
      exp_ac = 4'b0001 << (c % 4);
      n_checks++; if (st_a !== 4'b0000) begin n_fail++; $display("FAIL all_starve_rr: cycle %0d got %b expected 0000", c, st_a); end
`else
      exp_ac = 4'b0001;
      n_checks++; if (st_a[3] !== (c >= 8)) begin n_fail++;
        $display("FAIL all_starve3_fixed: cycle %0d got %b expected %b", c, st_a[3], (c >= 8)); end
`endif
      n_checks++; if (ac_a !== exp_ac) begin n_fail++; $display("FAIL all_ac: cycle %0d got %b expected %b", c, ac_a, exp_ac); end
      n_checks++; if (st_a !== m_st_a || st_b !== m_st_b) begin n_fail++;
        $display("FAIL all_starve_model: cycle %0d got %b/%b expected %b/%b", c, st_a, st_b, m_st_a, m_st_b); end
      if (c > 0) begin
        n_checks++; if (bcen_a !== 1'b1 || bl_a !== m_lbl) begin n_fail++;
          $display("FAIL all_bc: cycle %0d got bcen=%b lbl=%0d expected 1/%0d", c, bcen_a, bl_a, m_lbl); end
      end
    end
  endtask

  task automatic test_zero_tag();
    s_lbl[2] = '0; s_dat[2] = 32'hDEAD;
    apply(1'b0, 4'b0100);
    n_checks++; if (ac_a !== 4'b0100) begin n_fail++; $display("FAIL zero_ac: got %b expected 0100", ac_a); end
    apply(1'b0, 4'b0000);
    n_checks++; if (bcen_a !== 1'b0 || err_a !== 1'b1) begin n_fail++;
      $display("FAIL zero_bc: got bcen=%b err=%b expected 0/1", bcen_a, err_a); end
    repeat (10) apply(1'b0, 4'b0000);
    n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL zero_sticky: got err=%b expected 1", err_a); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin s_lbl[i] = LW'(i + 5); s_dat[i] = 32'hC000 + i; end
    apply(1'b1, 4'b0000);
    apply(1'b0, 4'b0010);
    n_checks++; if (ac_a !== 4'b0010) begin n_fail++; $display("FAIL mid_first_ac: got %b expected 0010", ac_a); end
    apply(1'b1, 4'b0010);
    n_checks++; if (ac_a !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ac: got %b expected 0000", ac_a); end
    n_checks++; if (bcen_a !== 1'b1 || bl_a !== 4'd6) begin n_fail++;
      $display("FAIL mid_pending_bc: got bcen=%b lbl=%0d expected 1/6", bcen_a, bl_a); end
    apply(1'b0, 4'b0110);
    n_checks++; if (bcen_a !== 1'b0 || err_a !== 1'b0 || bl_a !== '0) begin n_fail++;
      $display("FAIL mid_after_rst: got bcen=%b err=%b lbl=%0d expected 0/0/0", bcen_a, err_a, bl_a); end
    n_checks++; if (ac_a !== 4'b0010) begin n_fail++; $display("FAIL mid_ptr_reset: got %b expected 0010", ac_a); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin s_lbl[i] = LW'(i + 1); s_dat[i] = 32'hD000 + i; end
    apply(1'b1, 4'b0000);
    for (int c = 0; c < 8; c++) begin
      apply(1'b0, 4'b1001);
      n_checks++; if (st_b !== m_st_b || ac_b !== m_ac) begin n_fail++;
        $display("FAIL sat_model: cycle %0d got starve=%b ac=%b expected %b/%b", c, st_b, ac_b, m_st_b, m_ac); end
`ifndef CDB_ROUND_ROBIN_EN
      n_checks++; if (st_b[3] !== (c >= 3)) begin n_fail++;
        $display("FAIL sat_starve3: cycle %0d got %b expected %b", c, st_b[3], (c >= 3)); end
`endif
    end
    apply(1'b0, 4'b1000);
    n_checks++; if (ac_b !== 4'b1000) begin n_fail++; $display("FAIL sat_grant3: got %b expected 1000", ac_b); end
    apply(1'b0, 4'b0000);
    n_checks++; if (st_b[3] !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %b expected 0", st_b[3]); end
  endtask

  task automatic test_random();
    logic [3:0] nxt;
    logic       r;
    apply(1'b1, 4'b0000);
    for (int c = 0; c < 400; c++) begin
      nxt = req & ~m_ac;
      for (int i = 0; i < 4; i++) begin
        if (nxt[i] && $urandom_range(0, 9) == 0) nxt[i] = 1'b0;
        else if (!nxt[i] && $urandom_range(0, 2) != 0) begin
          nxt[i]   = 1'b1;
          s_lbl[i] = ($urandom_range(0, 15) == 0) ? '0 : LW'($urandom_range(1, 15));
          s_dat[i] = $urandom;
        end
      end
      r = ($urandom_range(0, 59) == 0);
      apply(r, nxt);
      n_checks++;
      if (ac_a !== m_ac || ac_b !== m_ac || bcen_a !== m_bcen || bcen_b !== m_bcen ||
          err_a !== m_err || err_b !== m_err || st_a !== m_st_a || st_b !== m_st_b ||
          (m_bcen && (bl_a !== m_lbl || bd_a !== m_dat || bl_b !== m_lbl || bd_b !== m_dat))) begin
        n_fail++;
        $display("FAIL random: cycle %0d got ac=%b bcen=%b lbl=%0h data=%0h st=%b/%b err=%b expected ac=%b bcen=%b lbl=%0h data=%0h st=%b/%b err=%b",
                 c, ac_a, bcen_a, bl_a, bd_a, st_a, st_b, err_a, m_ac, m_bcen, m_lbl, m_dat, m_st_a, m_st_b, m_err);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      lbl[i] = '0; dat[i] = '0; s_lbl[i] = '0; s_dat[i] = '0;
      w_a[i] = 0; w_b[i] = 0; nw_a[i] = 0; nw_b[i] = 0;
    end
    m_ptr = 0; n_ptr = 0; m_bcen = 0; n_bcen = 0; m_err = 0; n_err = 0;
    m_lbl = '0; n_lbl = '0; m_dat = '0; n_dat = '0;
    m_st_a = '0; n_st_a = '0; m_st_b = '0; n_st_b = '0; m_ac = '0;

    test_reset();
    test_single();
    test_all_request();
    test_zero_tag();
    test_reset_mid();
    test_saturation();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
